// File: rtl/sram_word_controller_if.sv
// MEM-stage request/response bundle for sram_word_controller.
// The master modport is the pipeline side; the slave modport is the controller.
interface sram_word_controller_if;
  logic        wrEnIn;
  logic        rdEnIn;
  logic [31:0] addressIn;
  logic [31:0] writeDataIn;
  logic [31:0] readDataOut;
  logic        readyOut;

  modport master (
    output wrEnIn, rdEnIn, addressIn, writeDataIn,
    input  readDataOut, readyOut
  );

  modport slave (
    input  wrEnIn, rdEnIn, addressIn, writeDataIn,
    output readDataOut, readyOut
  );
endinterface

// File: rtl/sram_word_controller.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM half accesses (low half first).
// Define SRAM_LAST_READ_CACHE_EN to add a one-entry last-read cache that answers repeat reads in IDLE.
module sram_word_controller #(
  parameter logic [31:0] BASE_ADDR     = 32'd1024,
  parameter int          ACCESS_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  sram_word_controller_if.slave        bus,
  inout  wire  [15:0]                  SRAM_DQInOut,
  output logic [17:0]                  SRAM_ADDROut,
  output logic                         SRAM_UB_NOut,
  output logic                         SRAM_LB_NOut,
  output logic                         SRAM_WE_NOut,
  output logic                         SRAM_CE_NOut,
  output logic                         SRAM_OE_NOut
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST_COUNT   = 4'(ACCESS_CYCLES - 1);
  localparam logic       SINGLE_CYCLE = (ACCESS_CYCLES == 1);

  state_t      state_q;
  logic [3:0]  count_q;
  logic        op_write_q;
  logic [16:0] word_q;
  logic [31:0] wdata_q;
  logic [15:0] rd_lo_q;
  logic [31:0] read_data_q;
  logic [17:0] addr_q;
  logic        we_n_q;
  logic        oe_n_q;
  logic        dq_oe_q;
  logic [15:0] dq_out_q;

  logic        request;
  logic        start;
  logic        cache_hit;
  logic [31:0] hit_data;
  logic [31:0] offset;
  logic [16:0] word_in;
  logic        unused_offset_bits;

  assign offset             = bus.addressIn - BASE_ADDR;
  assign word_in            = offset[18:2];
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
  assign request            = bus.wrEnIn | bus.rdEnIn;

`ifdef SRAM_LAST_READ_CACHE_EN
  logic        cache_valid_q;
  logic [16:0] cache_tag_q;
  logic [31:0] cache_data_q;

  // A pure read (write wins when both enables are high) that matches the valid tag is served in IDLE.
  assign cache_hit = (state_q == IDLE) && bus.rdEnIn && !bus.wrEnIn &&
                     cache_valid_q && (cache_tag_q == word_in);
  assign hit_data  = cache_data_q;

  // The entry is refreshed in DONE: read misses fill it, writes to the cached word keep it coherent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
    end else if (state_q == DONE) begin
      if (!op_write_q) begin
        cache_valid_q <= 1'b1;
        cache_tag_q   <= word_q;
        cache_data_q  <= read_data_q;
      end else if (cache_valid_q && (cache_tag_q == word_q)) begin
        cache_data_q  <= wdata_q;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_data  = '0;
`endif

  assign start           = (state_q == IDLE) && request && !cache_hit;
  assign bus.readyOut    = ((state_q == IDLE) && !start) || (state_q == DONE);
  assign bus.readDataOut = cache_hit ? hit_data : read_data_q;

  assign SRAM_DQInOut = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign SRAM_ADDROut = addr_q;
  assign SRAM_WE_NOut = we_n_q;
  assign SRAM_OE_NOut = oe_n_q;
  assign SRAM_UB_NOut = 1'b0;
  assign SRAM_LB_NOut = 1'b0;
  assign SRAM_CE_NOut = 1'b0;

  // WE_N is raised one cycle before each half ends so the driven data is held past the write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      op_write_q  <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      rd_lo_q     <= '0;
      read_data_q <= '0;
      addr_q      <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LO;
            count_q    <= '0;
            op_write_q <= bus.wrEnIn;
            word_q     <= word_in;
            wdata_q    <= bus.writeDataIn;
            addr_q     <= {word_in, 1'b0};
            we_n_q     <= !bus.wrEnIn || SINGLE_CYCLE;
            oe_n_q     <= bus.wrEnIn;
            dq_oe_q    <= bus.wrEnIn;
            dq_out_q   <= bus.writeDataIn[15:0];
          end else if (cache_hit) begin
            read_data_q <= hit_data;
          end
        end
        LO: begin
          if (count_q == LAST_COUNT) begin
            state_q  <= HI;
            count_q  <= '0;
            addr_q   <= {word_q, 1'b1};
            we_n_q   <= !op_write_q || SINGLE_CYCLE;
            dq_out_q <= wdata_q[31:16];
            if (!op_write_q) begin
              rd_lo_q <= SRAM_DQInOut;
            end
          end else begin
            count_q <= count_q + 4'd1;
            if ((count_q + 4'd1) == LAST_COUNT) begin
              we_n_q <= 1'b1;
            end
          end
        end
        HI: begin
          if (count_q == LAST_COUNT) begin
            state_q <= DONE;
            count_q <= '0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            if (!op_write_q) begin
              read_data_q <= {SRAM_DQInOut, rd_lo_q};
            end
          end else begin
            count_q <= count_q + 4'd1;
            if ((count_q + 4'd1) == LAST_COUNT) begin
              we_n_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_word_controller.sv
// Self-checking bench for sram_word_controller: behavioural SRAM, word-level reference model,
// directed scenarios plus randomized load/store traffic.
module tb_sram_word_controller;

  localparam int AC       = 2;
  localparam int FULL_LAT = 1 + 2 * AC;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sram_word_controller_if bus ();

  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;

  int checks = 0;
  int errors = 0;

  sram_word_controller #(
    .BASE_ADDR    (32'd1024),
    .ACCESS_CYCLES(AC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .SRAM_DQInOut(sram_dq),
    .SRAM_ADDROut(sram_addr),
    .SRAM_UB_NOut(ub_n),
    .SRAM_LB_NOut(lb_n),
    .SRAM_WE_NOut(we_n),
    .SRAM_CE_NOut(ce_n),
    .SRAM_OE_NOut(oe_n)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM: drives on OE_N low, stores on every clock with WE_N low.
  logic [15:0] sram [0:511];
  assign sram_dq = (!oe_n && we_n) ? sram[sram_addr[8:0]] : 16'hzzzz;
  always @(posedge clk) if (!we_n) sram[sram_addr[8:0]] <= sram_dq;

  int we_low_cnt = 0;
  int oe_low_cnt = 0;
  always @(posedge clk) begin
    if (!we_n) we_low_cnt++;
    if (!oe_n) oe_low_cnt++;
  end

  // Word-level reference: memory image, last completed read, and last-read cache contents.
  logic [31:0] ref_mem [0:255];
  logic [31:0] ref_last = '0;
  bit          ref_valid = 1'b0;
  int          ref_tag = 0;

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'd1024) >> 2;
    return int'(w[16:0]);
  endfunction

  function automatic int expected_latency(input bit wr, input bit rd, input int w);
`ifdef SRAM_LAST_READ_CACHE_EN
    if (!wr && rd && ref_valid && ref_tag == w) return 0;
`endif
    if (wr || rd) return FULL_LAT;
    return 0;
  endfunction

  function automatic void model_commit(input bit wr, input bit rd, input int w, input logic [31:0] d);
    if (wr) begin
      ref_mem[w] = d;
    end else if (rd) begin
      ref_last  = ref_mem[w];
      ref_valid = 1'b1;
      ref_tag   = w;
    end
  endfunction

  task automatic run_access(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data,
                            input bit scramble, output int lat, output int we_low, output int oe_low,
                            output logic [31:0] rdata);
    int we0, oe0;
    @(negedge clk);
    bus.wrEnIn = wr;
    bus.rdEnIn = rd;
    bus.addressIn = addr;
    bus.writeDataIn = data;
    we0 = we_low_cnt;
    oe0 = oe_low_cnt;
    lat = -1;
    for (int c = 0; c <= 4 * FULL_LAT; c++) begin
      #1;
      if (bus.readyOut) begin
        lat = c;
        break;
      end
      @(negedge clk);
      if (scramble) begin
        bus.addressIn   = 32'd1024 + 32'd4 * (32'd1000 + 32'($urandom_range(0, 1000)));
        bus.writeDataIn = $urandom;
      end
    end
    we_low = we_low_cnt - we0;
    oe_low = oe_low_cnt - oe0;
    rdata  = bus.readDataOut;
  endtask

  task automatic idle_cycles(input int n);
    @(negedge clk);
    bus.wrEnIn = 1'b0;
    bus.rdEnIn = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.wrEnIn = 1'b0;
    bus.rdEnIn = 1'b0;
    bus.addressIn = '0;
    bus.writeDataIn = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.readyOut !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 1", bus.readyOut); end
    checks++; if (we_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_we_n: got %0b expected 1", we_n); end
    checks++; if (oe_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_oe_n: got %0b expected 1", oe_n); end
    checks++; if (bus.readDataOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.readDataOut); end
    checks++; if (sram_addr !== 18'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", sram_addr); end
    checks++; if ({ub_n, lb_n, ce_n} !== 3'b000) begin errors++; $display("[TB] FAIL reset_static_pins: got %b expected 000", {ub_n, lb_n, ce_n}); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.readyOut !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready: got %0b expected 1", bus.readyOut); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_basic;
    int lat, wl, ol;
    logic [31:0] rd;
    run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, lat, wl, ol, rd);
    checks++; if (lat !== FULL_LAT) begin errors++; $display("[TB] FAIL write_latency: got %0d expected %0d", lat, FULL_LAT); end
    checks++; if (sram_addr !== 18'd1) begin errors++; $display("[TB] FAIL write_done_addr: got %h expected 1", sram_addr); end
    model_commit(1'b1, 1'b0, 0, 32'hDEADBEEF);
    idle_cycles(1);
    checks++; if (sram[0] !== 16'hBEEF) begin errors++; $display("[TB] FAIL write_lo_half: got %h expected BEEF", sram[0]); end
    checks++; if (sram[1] !== 16'hDEAD) begin errors++; $display("[TB] FAIL write_hi_half: got %h expected DEAD", sram[1]); end
    checks++; if (wl !== 2 * (AC - 1)) begin errors++; $display("[TB] FAIL write_we_cycles: got %0d expected %0d", wl, 2 * (AC - 1)); end
    checks++; if (ol !== 0) begin errors++; $display("[TB] FAIL write_oe_cycles: got %0d expected 0", ol); end
  endtask

  task automatic test_read_basic;
    int lat, wl, ol, elat;
    logic [31:0] rd, exp;
    exp  = ref_mem[0];
    elat = expected_latency(1'b0, 1'b1, 0);
    run_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, lat, wl, ol, rd);
    model_commit(1'b0, 1'b1, 0, 32'h0);
    checks++; if (lat !== elat) begin errors++; $display("[TB] FAIL read_latency: got %0d expected %0d", lat, elat); end
    checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL read_data: got %h expected %h", rd, exp); end
    checks++; if (ol !== 2 * AC) begin errors++; $display("[TB] FAIL read_oe_cycles: got %0d expected %0d", ol, 2 * AC); end
    checks++; if (wl !== 0) begin errors++; $display("[TB] FAIL read_we_cycles: got %0d expected 0", wl); end
    idle_cycles(3);
    #1;
    checks++; if (bus.readDataOut !== exp) begin errors++; $display("[TB] FAIL read_hold: got %h expected %h", bus.readDataOut, exp); end
  endtask

  task automatic test_back_to_back;
    int lat, wl, ol, elat;
    logic [31:0] rd;
    run_access(1'b1, 1'b0, 32'd1032, 32'h12345678, 1'b0, lat, wl, ol, rd);
    model_commit(1'b1, 1'b0, 2, 32'h12345678);
    checks++; if (lat !== FULL_LAT) begin errors++; $display("[TB] FAIL b2b_write_latency: got %0d expected %0d", lat, FULL_LAT); end
    elat = expected_latency(1'b0, 1'b1, 2);
    run_access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, lat, wl, ol, rd);
    model_commit(1'b0, 1'b1, 2, 32'h0);
    checks++; if (lat !== elat) begin errors++; $display("[TB] FAIL b2b_read_latency: got %0d expected %0d", lat, elat); end
    checks++; if (rd !== ref_mem[2]) begin errors++; $display("[TB] FAIL b2b_read_data: got %h expected %h", rd, ref_mem[2]); end
    checks++; if ({sram[5], sram[4]} !== 32'h12345678) begin errors++; $display("[TB] FAIL b2b_sram_image: got %h expected 12345678", {sram[5], sram[4]}); end
    idle_cycles(1);
  endtask

  task automatic test_write_priority;
    int lat, wl, ol;
    logic [31:0] rd, prev;
    prev = ref_last;
    run_access(1'b1, 1'b1, 32'd1036, 32'hA5A55A5A, 1'b0, lat, wl, ol, rd);
    model_commit(1'b1, 1'b1, 3, 32'hA5A55A5A);
    checks++; if (lat !== FULL_LAT) begin errors++; $display("[TB] FAIL prio_latency: got %0d expected %0d", lat, FULL_LAT); end
    checks++; if (rd !== prev) begin errors++; $display("[TB] FAIL prio_rdata_kept: got %h expected %h", rd, prev); end
    checks++; if (ol !== 0) begin errors++; $display("[TB] FAIL prio_no_read: got %0d oe cycles expected 0", ol); end
    idle_cycles(1);
    checks++; if ({sram[7], sram[6]} !== 32'hA5A55A5A) begin errors++; $display("[TB] FAIL prio_sram_image: got %h expected A5A55A5A", {sram[7], sram[6]}); end
  endtask

  task automatic test_reset_mid_write;
    int lat, wl, ol;
    logic [31:0] rd;
    @(negedge clk);
    bus.wrEnIn = 1'b1;
    bus.rdEnIn = 1'b0;
    bus.addressIn = 32'd1024 + 32'd800;
    bus.writeDataIn = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.wrEnIn = 1'b0;
    #1;
    checks++; if (bus.readyOut !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready: got %0b expected 1", bus.readyOut); end
    checks++; if (we_n !== 1'b1) begin errors++; $display("[TB] FAIL midrst_we_n: got %0b expected 1", we_n); end
    checks++; if (oe_n !== 1'b1) begin errors++; $display("[TB] FAIL midrst_oe_n: got %0b expected 1", oe_n); end
    @(negedge clk);
    rst = 1'b1;
    ref_valid = 1'b0;
    ref_last  = '0;
    #1;
    checks++; if (bus.readyOut !== 1'b1) begin errors++; $display("[TB] FAIL postrst_ready: got %0b expected 1", bus.readyOut); end
    checks++; if (bus.readDataOut !== 32'h0) begin errors++; $display("[TB] FAIL postrst_rdata: got %h expected 0", bus.readDataOut); end
    run_access(1'b1, 1'b0, 32'd1044, 32'h0F1E2D3C, 1'b0, lat, wl, ol, rd);
    model_commit(1'b1, 1'b0, 5, 32'h0F1E2D3C);
    checks++; if (lat !== FULL_LAT) begin errors++; $display("[TB] FAIL postrst_latency: got %0d expected %0d", lat, FULL_LAT); end
    idle_cycles(1);
  endtask

  task automatic test_cache;
    int lat, wl, ol, elat;
    logic [31:0] rd;
    for (int k = 0; k < 4; k++) begin
      bit wr;
      logic [31:0] d;
      wr   = (k == 2);
      d    = 32'h0BADF00D;
      elat = expected_latency(wr, !wr, 0);
      run_access(wr, !wr, 32'd1024, d, 1'b0, lat, wl, ol, rd);
      model_commit(wr, !wr, 0, d);
      checks++; if (lat !== elat) begin errors++; $display("[TB] FAIL cache_latency_%0d: got %0d expected %0d", k, lat, elat); end
      checks++; if (rd !== ref_last) begin errors++; $display("[TB] FAIL cache_rdata_%0d: got %h expected %h", k, rd, ref_last); end
      checks++; if (ol !== ((!wr && elat != 0) ? 2 * AC : 0)) begin errors++; $display("[TB] FAIL cache_oe_cycles_%0d: got %0d", k, ol); end
    end
    idle_cycles(1);
  endtask

  task automatic test_random;
    int lat, wl, ol, elat, w, sel;
    bit wr, rdn;
    logic [31:0] rd, addr, d;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      run_access(1'b1, 1'b0, 32'd1024 + 32'(4 * i), d, 1'b0, lat, wl, ol, rd);
      model_commit(1'b1, 1'b0, i, d);
      checks++; if (lat !== FULL_LAT) begin errors++; $display("[TB] FAIL preload_latency_%0d: got %0d expected %0d", i, lat, FULL_LAT); end
    end
    for (int i = 0; i < 40; i++) begin
      sel  = $urandom_range(0, 9);
      wr   = (sel <= 3) || (sel == 9);
      rdn  = (sel >= 4);
      w    = $urandom_range(0, 15);
      addr = 32'd1024 + 32'(4 * w) + 32'($urandom_range(0, 3));
      d    = $urandom;
      elat = expected_latency(wr, rdn, w);
      run_access(wr, rdn, addr, d, 1'b1, lat, wl, ol, rd);
      model_commit(wr, rdn, w, d);
      checks++; if (lat !== elat) begin errors++; $display("[TB] FAIL rand_latency_%0d: got %0d expected %0d", i, lat, elat); end
      checks++; if (rd !== ref_last) begin errors++; $display("[TB] FAIL rand_rdata_%0d: got %h expected %h", i, rd, ref_last); end
      checks++; if (wl !== (wr ? 2 * (AC - 1) : 0)) begin errors++; $display("[TB] FAIL rand_we_cycles_%0d: got %0d", i, wl); end
      checks++; if (ol !== ((!wr && elat != 0) ? 2 * AC : 0)) begin errors++; $display("[TB] FAIL rand_oe_cycles_%0d: got %0d", i, ol); end
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(2);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({sram[2 * i + 1], sram[2 * i]} !== ref_mem[i]) begin
        errors++;
        $display("[TB] FAIL rand_sram_word_%0d: got %h expected %h", i, {sram[2 * i + 1], sram[2 * i]}, ref_mem[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_back_to_back();
    test_write_priority();
    test_reset_mid_write();
    test_cache();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_word_controller.md
Name: sram_word_controller

Overview:
- Sequences the external 16-bit SRAM on behalf of the MEM stage.
- Turns each 32-bit load or store into two back-to-back 16-bit SRAM half accesses.
- Drives the SRAM control pins and provides the readyOut handshake that freezes the pipeline while an access is in flight.
- Sits between the MEM stage's ALU result, Rm value and memory enables and the board SRAM pins.

Parameters:
- BASE_ADDR, 1024: CPU byte address that maps to SRAM word 0.
- ACCESS_CYCLES, 2: clock cycles spent on each 16-bit half access (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wrEnIn  in  1  store request from MEM stage.
- rdEnIn  in  1  load request from MEM stage.
- addressIn  in  32  CPU byte address (ALU result).
- writeDataIn  in  32  store data (Val_Rm).
- readDataOut  out  32  load result.
- readyOut  out  1  high when the MEM stage may advance.
- SRAM_DQInOut  inout  16  SRAM data bus.
- SRAM_ADDROut  out  18  SRAM half-word address.
- SRAM_UB_NOut  out  1  upper byte enable, always 0.
- SRAM_LB_NOut  out  1  lower byte enable, always 0.
- SRAM_WE_NOut  out  1  write enable, active low.
- SRAM_CE_NOut  out  1  chip enable, always 0.
- SRAM_OE_NOut  out  1  output enable, active low.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, half-cycle counter=0, readDataOut=0, SRAM_ADDROut=0.
  - WE_N=1, OE_N=1, DQ high-Z.
  - readyOut follows its combinational rule.
- Address mapping: word = ((addressIn - BASE_ADDR) >> 2), truncated to 17 bits; addressIn[1:0] ignored. Low half goes to SRAM {word,0}, high half to SRAM {word,1}. Bits [15:0] are the low half.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - If wrEnIn|rdEnIn, latch op, address and writeDataIn, then go to LO.
  - If both enables are high, the write wins and the read is dropped.
- LO: stays ACCESS_CYCLES cycles, then goes to HI.
- HI: stays ACCESS_CYCLES cycles, then goes to DONE.
- DONE: one cycle, then unconditionally IDLE.
- readyOut (combinational):
  - 1 in IDLE with no request.
  - 0 in IDLE with a request, and in LO and HI.
  - 1 in DONE.
- Latency: request first seen at cycle 0 gives readyOut=1 at cycle 1+2*ACCESS_CYCLES (default: cycle 5).
- Request inputs must stay stable until readyOut=1. Changes after the IDLE latch are ignored and the latched access completes.
- Write in LO/HI:
  - SRAM_DQInOut drives the latched half.
  - WE_N=0 on every cycle of the half except the last, and 1 on the last cycle (data-hold).
  - OE_N=1.
- Read in LO/HI:
  - OE_N=0, WE_N=1, DQ high-Z.
  - The half is captured on the last cycle of each state.
  - readDataOut updates in DONE and holds until the next read completes. Writes never change readDataOut.
- SRAM_ADDROut is registered: {word,0} throughout LO and {word,1} throughout HI. It holds its last value in IDLE/DONE, with WE_N=1 and OE_N=1 there.
- Back-to-back requests: a request present in the IDLE cycle after DONE starts a new access immediately with readyOut=0. There are no extra bubbles.
- Reset asserted mid-access: the access is aborted and any write half may be partial. After rst deasserts the block is in IDLE.

Optional Feature:
- Macro: SRAM_LAST_READ_CACHE_EN.
- Defined: adds a one-entry cache holding the tag (17-bit word), data and a valid bit.
  - A read in IDLE whose word matches a valid tag completes that cycle: readyOut=1, readDataOut=cached data (combinational), no SRAM cycles, state stays IDLE.
  - A read miss fills the entry in DONE.
  - A write to the cached word updates the cached data in DONE.
  - Reset clears valid.
- Undefined: no cache; every read takes the full 1+2*ACCESS_CYCLES latency.

Test Plan:
- Idle, no enables → readyOut=1, WE_N=1, OE_N=1, DQ=Z.
- Write 0xDEADBEEF to 1024 → SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; readyOut=0 for cycles 0-4, 1 at cycle 5.
- Read 1024 after the above → readDataOut=0xDEADBEEF at DONE (cycle 5), then held.
- Write 0x12345678 to 1032, then immediately read 1032 → SRAM[4]=0x5678, SRAM[5]=0x1234, read returns 0x12345678, second access starts on the cycle after the first DONE.
- wrEnIn=rdEnIn=1, addressIn=1036, data 0xA5A5_5A5A → write performed, readDataOut unchanged; rst pulsed low at cycle 2 of a write → IDLE immediately, readyOut=1 with no request, WE_N=1.
- With SRAM_LAST_READ_CACHE_EN: read 1024 twice → second read readyOut=1 in cycle 0, no OE_N assertion; write 0x0BADF00D to 1024 then read → returns 0x0BADF00D in cycle 0.
